ball_layer_mux: RTL and testbench

Parametrised, registered priority multiplexer for the ball drawing layer: selects one of `NUM_BALLS` ball pixel sources per pixel and drives a single ball RGB/request pair into the object-level draw mux. Per-ball `ballEnable` masks dead balls. Optional rotating priority advances once per frame. Rope-to-ball and player-to-ball overlaps are accumulated over each frame and published as a per-frame hit snapshot for the game-control FSM (ball split, life loss).

---
 rtl/ball_layer_mux.sv | 137 +++++++++++++
 tb/tb_ball_layer_mux.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ball_layer_mux.sv
// Registered priority mux for the ball drawing layer, with per-frame
// rope/player hit snapshots and optional rotating priority.
//
// Ports:
//   clk, resetN       pixel clock, async active-low reset
//   ballRGB           packed per-ball colours (channel i at [i*RGB_W +: RGB_W])
//   ballRequest       per-ball "pixel inside ball"
//   ballEnable        per-ball alive mask
//   startOfFrame      one-cycle frame-start pulse
//   ropeRequest       rope pixel active
//   playerRequest     player pixel active
//   ballDrawRequest   registered draw request of the selected ball
//   ballRGBout        registered colour of the selected ball
//   ropeHit/playerHit per-ball overlaps of the last completed frame
//   hitValid          one-cycle pulse when the hit snapshot updates
//   priorityPtr       current highest-priority channel
module ball_layer_mux #(
   parameter int NUM_BALLS = 4,
   parameter int RGB_W     = 8,
   parameter int ROTATE    = 0,
   localparam int PW = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1
) (
   input  logic                       clk,
   input  logic                       resetN,
   input  logic [NUM_BALLS*RGB_W-1:0] ballRGB,
   input  logic [NUM_BALLS-1:0]       ballRequest,
   input  logic [NUM_BALLS-1:0]       ballEnable,
   input  logic                       startOfFrame,
   input  logic                       ropeRequest,
   input  logic                       playerRequest,
   output logic                       ballDrawRequest,
   output logic [RGB_W-1:0]           ballRGBout,
   output logic [NUM_BALLS-1:0]       ropeHit,
   output logic [NUM_BALLS-1:0]       playerHit,
   output logic                       hitValid,
   output logic [PW-1:0]              priorityPtr
);

   logic [NUM_BALLS-1:0] act;
   logic [NUM_BALLS-1:0] rope_now;
   logic [NUM_BALLS-1:0] plyr_now;
   logic [RGB_W-1:0]     rgb_a [NUM_BALLS];

   logic                 draw_d, draw_q;
   logic [RGB_W-1:0]     rgb_d, rgb_q;
   logic [PW-1:0]        ptr_d, ptr_q;
   logic [NUM_BALLS-1:0] racc_d, racc_q;
   logic [NUM_BALLS-1:0] pacc_d, pacc_q;
   logic [NUM_BALLS-1:0] rhit_d, rhit_q;
   logic [NUM_BALLS-1:0] phit_d, phit_q;
   logic                 hv_d, hv_q;

   logic [PW:0]          sum;
   logic [PW-1:0]        idx;

   for (genvar g = 0; g < NUM_BALLS; g++) begin : g_unpack
      assign rgb_a[g] = ballRGB[g*RGB_W +: RGB_W];
   end

   assign act      = ballRequest & ballEnable;
   assign rope_now = act & {NUM_BALLS{ropeRequest}};
   assign plyr_now = act & {NUM_BALLS{playerRequest}};

   // Scan from the pointer, wrapping modulo NUM_BALLS; first hit wins.
   // In fixed mode the pointer stays 0, giving lowest-index priority.
   always_comb begin
      draw_d = 1'b0;
      rgb_d  = '0;
      sum    = '0;
      idx    = '0;
      for (int k = 0; k < NUM_BALLS; k++) begin
         sum = {1'b0, ptr_q} + (PW+1)'(k);
         if (sum >= (PW+1)'(NUM_BALLS)) begin
            sum = sum - (PW+1)'(NUM_BALLS);
         end
         idx = sum[PW-1:0];
         if (!draw_d && act[idx]) begin
            draw_d = 1'b1;
            rgb_d  = rgb_a[idx];
         end
      end
   end

   always_comb begin
      ptr_d  = ptr_q;
      racc_d = racc_q | rope_now;
      pacc_d = pacc_q | plyr_now;
      rhit_d = rhit_q;
      phit_d = phit_q;
      hv_d   = 1'b0;
      if (startOfFrame) begin
         // Hits in the start-of-frame cycle close out the ending frame.
         rhit_d = racc_q | rope_now;
         phit_d = pacc_q | plyr_now;
         racc_d = '0;
         pacc_d = '0;
         hv_d   = 1'b1;
         if (ROTATE != 0) begin
            if (ptr_q == PW'(NUM_BALLS-1)) begin
               ptr_d = '0;
            end else begin
               ptr_d = ptr_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         draw_q <= 1'b0;
         rgb_q  <= '0;
         ptr_q  <= '0;
         racc_q <= '0;
         pacc_q <= '0;
         rhit_q <= '0;
         phit_q <= '0;
         hv_q   <= 1'b0;
      end else begin
         draw_q <= draw_d;
         rgb_q  <= rgb_d;
         ptr_q  <= ptr_d;
         racc_q <= racc_d;
         pacc_q <= pacc_d;
         rhit_q <= rhit_d;
         phit_q <= phit_d;
         hv_q   <= hv_d;
      end
   end

   assign ballDrawRequest = draw_q;
   assign ballRGBout      = rgb_q;
   assign ropeHit         = rhit_q;
   assign playerHit       = phit_q;
   assign hitValid        = hv_q;
   assign priorityPtr     = ptr_q;

endmodule

// File: tb/tb_ball_layer_mux.sv
// Scoreboard bench for ball_layer_mux: a fixed-priority and a rotating
// instance share stimulus and are checked against a frame-level model.
module tb_ball_layer_mux;

   localparam int N = 4;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         resetN;
   logic [N*W-1:0] ballRGB;
   logic [N-1:0] ballRequest, ballEnable;
   logic         startOfFrame, ropeRequest, playerRequest;

   logic         dr0, dr1, hv0, hv1;
   logic [W-1:0] rgb0, rgb1;
   logic [N-1:0] rh0, rh1, ph0, ph1;
   logic [1:0]   pp0, pp1;

   always #5 clk = ~clk;

   ball_layer_mux #(.NUM_BALLS(N), .RGB_W(W), .ROTATE(0)) u_fix (
      .clk(clk), .resetN(resetN), .ballRGB(ballRGB),
      .ballRequest(ballRequest), .ballEnable(ballEnable),
      .startOfFrame(startOfFrame), .ropeRequest(ropeRequest),
      .playerRequest(playerRequest), .ballDrawRequest(dr0),
      .ballRGBout(rgb0), .ropeHit(rh0), .playerHit(ph0),
      .hitValid(hv0), .priorityPtr(pp0));

   ball_layer_mux #(.NUM_BALLS(N), .RGB_W(W), .ROTATE(1)) u_rot (
      .clk(clk), .resetN(resetN), .ballRGB(ballRGB),
      .ballRequest(ballRequest), .ballEnable(ballEnable),
      .startOfFrame(startOfFrame), .ropeRequest(ropeRequest),
      .playerRequest(playerRequest), .ballDrawRequest(dr1),
      .ballRGBout(rgb1), .ropeHit(rh1), .playerHit(ph1),
      .hitValid(hv1), .priorityPtr(pp1));

   typedef struct {
      bit       dr0, dr1;
      bit [7:0] rgb0, rgb1;
      bit [3:0] rh, ph;
      bit       hv;
      int       ptr;
   } exp_t;

   exp_t q[$];
   int   nvec = 0;
   int   nerr = 0;

   // Frame-level model state
   int       m_ptr = 0;
   bit [3:0] m_racc = 0, m_pacc = 0, m_rh = 0, m_ph = 0;

   task automatic chk(input string nm, input int act_v, input int exp_v);
      if (act_v != exp_v) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act_v, exp_v, $time);
      end
   endtask

   // Pick the first active ball scanning from 'start' modulo N.
   function automatic void pick(input bit [3:0] a, input bit [31:0] c,
                                input int start, output bit d,
                                output bit [7:0] col);
      d = 0;
      col = 0;
      for (int k = 0; k < N; k++) begin
         int j;
         j = (start + k) % N;
         if (!d && a[j]) begin
            d = 1;
            col = c[j*8 +: 8];
         end
      end
   endfunction

   task automatic drive(input bit rn, input bit [3:0] req,
                        input bit [3:0] en, input bit [31:0] col,
                        input bit sof, input bit rope, input bit pl);
      exp_t e;
      bit [3:0] a, rn_h, pn_h;
      @(negedge clk);
      resetN = rn;
      ballRequest = req;
      ballEnable = en;
      ballRGB = col;
      startOfFrame = sof;
      ropeRequest = rope;
      playerRequest = pl;
      e = '{default: 0};
      if (!rn) begin
         m_ptr = 0;
         m_racc = 0;
         m_pacc = 0;
         m_rh = 0;
         m_ph = 0;
      end else begin
         a = req & en;
         rn_h = rope ? a : 4'b0;
         pn_h = pl ? a : 4'b0;
         pick(a, col, 0, e.dr0, e.rgb0);
         pick(a, col, m_ptr, e.dr1, e.rgb1);
         if (sof) begin
            m_rh = m_racc | rn_h;
            m_ph = m_pacc | pn_h;
            m_racc = 0;
            m_pacc = 0;
            m_ptr = (m_ptr + 1) % N;
            e.hv = 1;
         end else begin
            m_racc |= rn_h;
            m_pacc |= pn_h;
         end
         e.rh = m_rh;
         e.ph = m_ph;
         e.ptr = m_ptr;
      end
      q.push_back(e);
   endtask

   // Monitor: compare every registered output one step after each edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            nvec++;
            chk("fix_draw", dr0, e.dr0);
            chk("fix_rgb", rgb0, e.rgb0);
            chk("fix_ropeHit", rh0, e.rh);
            chk("fix_playerHit", ph0, e.ph);
            chk("fix_hitValid", hv0, e.hv);
            chk("fix_ptr", pp0, 0);
            chk("rot_draw", dr1, e.dr1);
            chk("rot_rgb", rgb1, e.rgb1);
            chk("rot_ropeHit", rh1, e.rh);
            chk("rot_playerHit", ph1, e.ph);
            chk("rot_hitValid", hv1, e.hv);
            chk("rot_ptr", pp1, e.ptr);
         end
      end
   end

   // Directed checks of literal values, taken after the following edge.
   task automatic after_edge();
      @(posedge clk);
      #2;
   endtask

   localparam bit [31:0] C_FIX = 32'h00E0_1C00;
   localparam bit [31:0] C_ROT = 32'h1312_1110;

   initial begin
      bit [31:0] crot;
      bit [7:0]  seq [5];
      resetN = 1'b0;
      ballRGB = '0;
      ballRequest = '0;
      ballEnable = '0;
      startOfFrame = 1'b0;
      ropeRequest = 1'b0;
      playerRequest = 1'b0;

      drive(0, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0);

      // Fixed priority and enable mask
      drive(1, 4'b0110, 4'b1111, C_FIX, 0, 0, 0);
      after_edge();
      chk("tp_fix_rgb", rgb0, 8'h1C);
      chk("tp_fix_draw", dr0, 1);
      drive(1, 4'b0110, 4'b1101, C_FIX, 0, 0, 0);
      after_edge();
      chk("tp_mask_rgb", rgb0, 8'hE0);
      drive(1, 4'b0110, 4'b1001, C_FIX, 0, 0, 0);
      after_edge();
      chk("tp_mask_none_draw", dr0, 0);
      chk("tp_mask_none_rgb", rgb0, 8'h00);

      // Rotation over four frames
      crot = C_ROT;
      seq = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
      for (int f = 0; f < 5; f++) begin
         drive(1, 4'b1111, 4'b1111, crot, 0, 0, 0);
         after_edge();
         chk("tp_rot_rgb", rgb1, seq[f]);
         if (f < 4) drive(1, 4'b1111, 4'b1111, crot, 1, 0, 0);
      end
      after_edge();
      chk("tp_rot_wrap", pp1, 0);

      // Rope hit including the start-of-frame cycle
      drive(1, 0, 4'b1111, 0, 1, 0, 0);
      drive(1, 4'b0100, 4'b1111, 0, 0, 1, 0);
      drive(1, 0, 4'b1111, 0, 0, 0, 0);
      drive(1, 4'b0001, 4'b1111, 0, 1, 1, 0);
      after_edge();
      chk("tp_rope_hit", rh0, 4'b0101);
      chk("tp_rope_player", ph0, 0);
      chk("tp_rope_hv", hv0, 1);
      drive(1, 0, 4'b1111, 0, 0, 0, 0);
      after_edge();
      chk("tp_rope_hv_drop", hv0, 0);
      drive(1, 0, 4'b1111, 0, 1, 0, 0);
      after_edge();
      chk("tp_rope_clear", rh0, 0);

      // Player hit on a dead ball, then alive
      drive(1, 4'b1000, 4'b0111, 0, 0, 0, 1);
      drive(1, 0, 4'b1111, 0, 1, 0, 0);
      after_edge();
      chk("tp_dead_player", ph0, 0);
      drive(1, 4'b1000, 4'b1111, 0, 0, 0, 1);
      drive(1, 0, 4'b1111, 0, 1, 0, 0);
      after_edge();
      chk("tp_live_player", ph0, 4'b1000);

      // Reset mid-frame
      drive(1, 4'b0011, 4'b1111, 0, 0, 1, 0);
      drive(0, 0, 4'b1111, 0, 0, 0, 0);
      after_edge();
      chk("tp_rst_rope", rh0, 0);
      chk("tp_rst_ptr", pp1, 0);
      drive(0, 0, 4'b1111, 0, 0, 0, 0);
      drive(1, 0, 4'b1111, 0, 0, 0, 0);
      after_edge();
      chk("tp_rst_ptr_pre", pp1, 0);
      drive(1, 0, 4'b1111, 0, 1, 0, 0);
      after_edge();
      chk("tp_rst_rope_post", rh1, 0);
      chk("tp_rst_hv_post", hv1, 1);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         bit rn;
         rn = ($urandom_range(0, 199) != 0);
         drive(rn, 4'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF,
               $urandom, ($urandom_range(0, 15) == 0),
               ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
      end
      drive(1, 0, 0, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #3;
      if (q.size() != 0) begin
         nerr++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
